pc_stack_unit: RTL and testbench
================================

# pc_stack_unit

Parametrised program-counter and call/data-stack unit: the next generation of the core's PC stage. It sequences the instruction address, services JMP/CALL/RET/PUSH/POP/GSA/SWITCH, and issues one-cycle register-file write requests for stack reads. Compared with the first-generation PC, it adds:

- configurable PC, data and stack widths;
- full-width POP data;
- explicit stack-full and stack-empty status;
- write requests that self-clear after one edge;
- optional overflow/underflow protection.

It sits between the decoder/ALU result bus and the instruction memory address port.

## Interface
Parameters:
- PC_WIDTH, 16, instruction address width.
- DATA_WIDTH, 32, stack entry and result width; must be > PC_WIDTH.
- STACK_DEPTH, 1024, number of stack entries; power of two, ≥ 2.
- REG_ADDR_WIDTH, 8, register-file write address width.
- SWITCH_REG_ADDR, 8'h24, register written by SWITCH.

Ports:
- clock  in  1  system clock; all state updates on falling edge.
- reset_n  in  1  synchronous, active-low reset, sampled on falling edge of clock.
- init_flag  in  1  run enable; low = hold all state, no write request.
- JMP_flag, CALL_flag, RET_flag, PUSH_flag, POP_flag, GSA_flag, SWITCH_flag  in  1 each  operation requests.
- result  in  DATA_WIDTH  operand: target address, push value or destination register.
- pc  out  PC_WIDTH  current instruction address.
- reg_write_en  out  1  register-file write strobe, one edge wide.
- reg_write_addr  out  REG_ADDR_WIDTH  write address.
- reg_write_data  out  DATA_WIDTH  write data.
- stack_count  out  $clog2(STACK_DEPTH)+1  occupied entries.
- stack_full  out  1  stack_count == STACK_DEPTH.
- stack_empty  out  1  stack_count == 0.
- fault  out  1  sticky overflow/underflow flag.

## Operation
- Active edge: a falling edge with reset_n=1 and init_flag=1. Exactly one operation executes per active edge.
- Priority: JMP > CALL > RET > PUSH > POP > GSA > SWITCH > sequential.
- Stack is a register array plus a top pointer equal to stack_count. A push writes entry[count], then count+1. A pop does count−1, then reads entry[count−1].
- JMP: pc ← result[PC_WIDTH-1:0].
- CALL: push zero-extended pc+1; pc ← result[PC_WIDTH-1:0].
- RET: pop; pc ← popped[PC_WIDTH-1:0].
- PUSH: push result; pc ← pc+1.
- POP: pop; reg_write_en=1, addr=result[REG_ADDR_WIDTH-1:0], data=popped (full DATA_WIDTH); pc ← pc+1.
- GSA: reg_write_en=1, addr=result[REG_ADDR_WIDTH-1:0], data=zero-extended stack_count; pc ← pc+1.
- SWITCH: pc ← result[PC_WIDTH-1:0]; reg_write_en=1, addr=SWITCH_REG_ADDR, data={0…, result[PC_WIDTH]}.
- No flag: pc ← pc+1.
- pc arithmetic wraps modulo 2^PC_WIDTH.
- reg_write_en is low after every edge that is not a POP/GSA/SWITCH execution. addr and data are 0 whenever reg_write_en is 0.
- init_flag=0: pc, stack and fault hold; reg_write_en=0.

## Timing
- All outputs are registered and change only on falling edges. Operation latency is one falling edge.
- stack_full and stack_empty are derived combinationally from the registered stack_count.
- Reset: pc=0, reg_write_en=0, reg_write_addr=0, reg_write_data=0, stack_count=0, fault=0, stack_empty=1, stack_full=0. Stack array contents are not reset.
- Reset has priority over init_flag and all operation flags. Reset asserted mid-sequence discards the stack on that edge.
- A flag held for N active edges executes N times.
- Boundary conditions:
  - Push when full, or pop/RET when empty: behaviour is set by the configuration below.
  - Push at count = STACK_DEPTH−1 is legal and makes stack_full=1.
  - Pop at count=1 is legal and makes stack_empty=1.

## Configuration
- PC_STACK_GUARD_EN defined:
  - An illegal push (CALL/PUSH while full) or pop (RET/POP while empty) is suppressed: no stack change, no reg write, pc holds, fault ← 1.
  - While fault=1, every active edge holds all state; only reset clears fault.
- PC_STACK_GUARD_EN undefined:
  - The pointer wraps modulo STACK_DEPTH.
  - Reported stack_count is STACK_DEPTH when full. A push while full overwrites entry 0 and sets count to 1. A pop while empty reads entry STACK_DEPTH−1 and sets count to STACK_DEPTH−1.
  - fault is tied 0.

## Test plan
- Reset then 3 idle active edges → pc=3, stack_empty=1, reg_write_en never high.
- pc=5, CALL result=0x40 → pc=0x40, count=1. Then RET → pc=6, count=0.
- PUSH result=0xDEADBEEF, then POP result=0x07 → reg_write_en for one edge, addr=0x07, data=0xDEADBEEF, count=0.
- SWITCH result=0x1_0020 (PC_WIDTH=16) → pc=0x0020, addr=0x24, data=1. GSA after 2 pushes → data=2.
- JMP and CALL asserted together with result=0x10 → pc=0x10, count unchanged. init_flag low → pc frozen.
- With STACK_DEPTH=4 and guard on: 5 PUSHes → 5th sets fault=1, count=4, pc frozen until reset_n=0. With guard off: 5th PUSH → count=1.

Source files
------------

// File: rtl/pc_stack_unit_if.sv
// -----------------------------------------------------------------------------
// pc_stack_unit_if
// Groups the decoder/ALU-side request bus and the status/write-back bus of the
// PC and stack unit.
//   master : decoder side; drives the run enable, operation flags and result,
//            and observes pc, the register write request and the stack status.
//   slave  : the pc_stack_unit itself.
// Signals:
//   init_flag                   run enable
//   JMP/CALL/RET/PUSH/POP/GSA/SWITCH_flag  operation requests
//   result        [DATA_WIDTH]  operand: target, push value or destination reg
//   pc            [PC_WIDTH]    current instruction address
//   reg_write_en/addr/data      one-edge register-file write request
//   stack_count   [CNT_WIDTH]   occupied entries
//   stack_full, stack_empty     stack status
//   fault                       sticky overflow/underflow flag
// -----------------------------------------------------------------------------
interface pc_stack_unit_if #(
    parameter int PC_WIDTH       = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int STACK_DEPTH    = 1024,
    parameter int REG_ADDR_WIDTH = 8
);
    localparam int CNT_WIDTH = $clog2(STACK_DEPTH) + 1;

    logic                      init_flag;
    logic                      JMP_flag;
    logic                      CALL_flag;
    logic                      RET_flag;
    logic                      PUSH_flag;
    logic                      POP_flag;
    logic                      GSA_flag;
    logic                      SWITCH_flag;
    logic [DATA_WIDTH-1:0]     result;
    logic [PC_WIDTH-1:0]       pc;
    logic                      reg_write_en;
    logic [REG_ADDR_WIDTH-1:0] reg_write_addr;
    logic [DATA_WIDTH-1:0]     reg_write_data;
    logic [CNT_WIDTH-1:0]      stack_count;
    logic                      stack_full;
    logic                      stack_empty;
    logic                      fault;

    modport master (
        output init_flag, JMP_flag, CALL_flag, RET_flag, PUSH_flag, POP_flag,
               GSA_flag, SWITCH_flag, result,
        input  pc, reg_write_en, reg_write_addr, reg_write_data, stack_count,
               stack_full, stack_empty, fault
    );

    modport slave (
        input  init_flag, JMP_flag, CALL_flag, RET_flag, PUSH_flag, POP_flag,
               GSA_flag, SWITCH_flag, result,
        output pc, reg_write_en, reg_write_addr, reg_write_data, stack_count,
               stack_full, stack_empty, fault
    );
endinterface

// File: rtl/pc_stack_unit.sv
// -----------------------------------------------------------------------------
// pc_stack_unit
// Program counter plus call/data stack. Executes one of JMP, CALL, RET, PUSH,
// POP, GSA, SWITCH (in that priority) or a sequential increment on every
// falling edge where reset_n=1 and init_flag=1, and issues one-edge-wide
// register-file write requests for POP, GSA and SWITCH.
// Ports:
//   clock    system clock, all state updates on the falling edge
//   reset_n  synchronous active-low reset, sampled on the falling edge
//   bus      pc_stack_unit_if.slave (requests in, pc/write/status out)
// Optional feature macro: PC_STACK_GUARD_EN
//   defined   : illegal push/pop is suppressed, fault is set and the unit
//               freezes until reset.
//   undefined : the stack pointer wraps modulo STACK_DEPTH, fault is tied 0.
// -----------------------------------------------------------------------------
module pc_stack_unit #(
    parameter int                          PC_WIDTH        = 16,
    parameter int                          DATA_WIDTH      = 32,
    parameter int                          STACK_DEPTH     = 1024,
    parameter int                          REG_ADDR_WIDTH  = 8,
    parameter logic [REG_ADDR_WIDTH-1:0]   SWITCH_REG_ADDR = 8'h24
) (
    input  logic           clock,
    input  logic           reset_n,
    pc_stack_unit_if.slave bus
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int CW = AW + 1;

`ifdef PC_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic [DATA_WIDTH-1:0]     r_stack [STACK_DEPTH];
    logic [PC_WIDTH-1:0]       r_pc;
    logic [CW-1:0]             r_count;
    logic                      r_we;
    logic [REG_ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic                      r_fault;

    logic [PC_WIDTH-1:0]       w_next_pc;
    logic [CW-1:0]             w_next_count;
    logic                      w_next_we;
    logic [REG_ADDR_WIDTH-1:0] w_next_waddr;
    logic [DATA_WIDTH-1:0]     w_next_wdata;
    logic                      w_next_fault;
    logic                      w_push_en;
    logic [DATA_WIDTH-1:0]     w_push_data;
    logic [PC_WIDTH-1:0]       w_pc_inc;
    logic [CW-1:0]             w_push_count;
    logic [CW-1:0]             w_pop_count;
    logic [DATA_WIDTH-1:0]     w_pop_data;
    logic                      w_push_ok;
    logic                      w_pop_ok;
    logic                      w_halted;

    assign w_pc_inc = r_pc + PC_WIDTH'(1);

    // Wrapping pointer arithmetic: count == STACK_DEPTH reads as index 0 on a
    // push, and a pop from 0 lands on STACK_DEPTH-1. With the guard enabled
    // these cases are never taken, so the same expressions serve both builds.
    assign w_push_count = (r_count == CW'(STACK_DEPTH)) ? CW'(1) : (r_count + CW'(1));
    assign w_pop_count  = (r_count == CW'(0)) ? CW'(STACK_DEPTH - 1) : (r_count - CW'(1));
    assign w_pop_data   = r_stack[w_pop_count[AW-1:0]];

    assign w_push_ok = !GUARD || (r_count != CW'(STACK_DEPTH));
    assign w_pop_ok  = !GUARD || (r_count != CW'(0));
    assign w_halted  = GUARD && r_fault;

    // Next-state decode: one operation per active edge, fixed priority.
    always_comb begin
        w_next_pc    = r_pc;
        w_next_count = r_count;
        w_next_we    = 1'b0;
        w_next_waddr = '0;
        w_next_wdata = '0;
        w_next_fault = r_fault;
        w_push_en    = 1'b0;
        w_push_data  = '0;
        if (!bus.init_flag || w_halted) begin
            // hold everything; the write strobe still drops
            w_next_pc = r_pc;
        end else if (bus.JMP_flag) begin
            w_next_pc = bus.result[PC_WIDTH-1:0];
        end else if (bus.CALL_flag) begin
            if (w_push_ok) begin
                w_push_en    = 1'b1;
                w_push_data  = DATA_WIDTH'(w_pc_inc);
                w_next_count = w_push_count;
                w_next_pc    = bus.result[PC_WIDTH-1:0];
            end else begin
                w_next_fault = 1'b1;
            end
        end else if (bus.RET_flag) begin
            if (w_pop_ok) begin
                w_next_count = w_pop_count;
                w_next_pc    = w_pop_data[PC_WIDTH-1:0];
            end else begin
                w_next_fault = 1'b1;
            end
        end else if (bus.PUSH_flag) begin
            if (w_push_ok) begin
                w_push_en    = 1'b1;
                w_push_data  = bus.result;
                w_next_count = w_push_count;
                w_next_pc    = w_pc_inc;
            end else begin
                w_next_fault = 1'b1;
            end
        end else if (bus.POP_flag) begin
            if (w_pop_ok) begin
                w_next_count = w_pop_count;
                w_next_we    = 1'b1;
                w_next_waddr = bus.result[REG_ADDR_WIDTH-1:0];
                w_next_wdata = w_pop_data;
                w_next_pc    = w_pc_inc;
            end else begin
                w_next_fault = 1'b1;
            end
        end else if (bus.GSA_flag) begin
            w_next_we    = 1'b1;
            w_next_waddr = bus.result[REG_ADDR_WIDTH-1:0];
            w_next_wdata = DATA_WIDTH'(r_count);
            w_next_pc    = w_pc_inc;
        end else if (bus.SWITCH_flag) begin
            // bit PC_WIDTH of the operand selects the bank reported to software
            w_next_pc    = bus.result[PC_WIDTH-1:0];
            w_next_we    = 1'b1;
            w_next_waddr = SWITCH_REG_ADDR;
            w_next_wdata = DATA_WIDTH'(bus.result[PC_WIDTH]);
        end else begin
            w_next_pc = w_pc_inc;
        end
    end

    // Control/status registers with synchronous reset on the falling edge.
    always_ff @(negedge clock) begin
        if (!reset_n) begin
            r_pc    <= '0;
            r_count <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_fault <= 1'b0;
        end else begin
            r_pc    <= w_next_pc;
            r_count <= w_next_count;
            r_we    <= w_next_we;
            r_waddr <= w_next_waddr;
            r_wdata <= w_next_wdata;
            r_fault <= GUARD ? w_next_fault : 1'b0;
        end
    end

    // Stack storage: not reset; written only on a surviving push.
    always_ff @(negedge clock) begin
        if (reset_n && w_push_en) begin
            r_stack[r_count[AW-1:0]] <= w_push_data;
        end
    end

    assign bus.pc             = r_pc;
    assign bus.reg_write_en   = r_we;
    assign bus.reg_write_addr = r_waddr;
    assign bus.reg_write_data = r_wdata;
    assign bus.stack_count    = r_count;
    assign bus.stack_full     = (r_count == CW'(STACK_DEPTH));
    assign bus.stack_empty    = (r_count == CW'(0));
    assign bus.fault          = GUARD ? r_fault : 1'b0;
endmodule

// File: tb/tb_pc_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_stack_unit
// Directed bench for pc_stack_unit with STACK_DEPTH=4 so the full/wrap cases
// are reachable. Expected values are hand-computed; the overflow section
// follows PC_STACK_GUARD_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_pc_stack_unit;
    localparam int PCW = 16;
    localparam int DW  = 32;
    localparam int SD  = 4;
    localparam int RAW = 8;

    // operation encodings for run_op: {JMP,CALL,RET,PUSH,POP,GSA,SWITCH}
    localparam logic [6:0] OP_NONE   = 7'b000_0000;
    localparam logic [6:0] OP_JMP    = 7'b100_0000;
    localparam logic [6:0] OP_CALL   = 7'b010_0000;
    localparam logic [6:0] OP_RET    = 7'b001_0000;
    localparam logic [6:0] OP_PUSH   = 7'b000_1000;
    localparam logic [6:0] OP_POP    = 7'b000_0100;
    localparam logic [6:0] OP_GSA    = 7'b000_0010;
    localparam logic [6:0] OP_SWITCH = 7'b000_0001;

    logic clock;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    pc_stack_unit_if #(.PC_WIDTH(PCW), .DATA_WIDTH(DW), .STACK_DEPTH(SD),
                       .REG_ADDR_WIDTH(RAW)) bus ();

    pc_stack_unit #(.PC_WIDTH(PCW), .DATA_WIDTH(DW), .STACK_DEPTH(SD),
                    .REG_ADDR_WIDTH(RAW), .SWITCH_REG_ADDR(8'h24))
        dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    // free-running clock, 10 time-unit period
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // apply one operation across a single falling edge, then settle
    task automatic run_op(input logic [6:0] ops, input logic [31:0] res, input logic init);
        {bus.JMP_flag, bus.CALL_flag, bus.RET_flag, bus.PUSH_flag,
         bus.POP_flag, bus.GSA_flag, bus.SWITCH_flag} = ops;
        bus.result    = res;
        bus.init_flag = init;
        @(negedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        run_op(OP_NONE, 32'h0, 1'b1);
        run_op(OP_PUSH, 32'h1234, 1'b1);
        reset_n = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        run_op(OP_NONE, 32'h0, 1'b0);
        apply_reset();

        check_eq("rst_pc",    32'(bus.pc), 32'h0);
        check_eq("rst_we",    32'(bus.reg_write_en), 32'h0);
        check_eq("rst_addr",  32'(bus.reg_write_addr), 32'h0);
        check_eq("rst_data",  bus.reg_write_data, 32'h0);
        check_eq("rst_count", 32'(bus.stack_count), 32'h0);
        check_eq("rst_empty", 32'(bus.stack_empty), 32'h1);
        check_eq("rst_full",  32'(bus.stack_full), 32'h0);
        check_eq("rst_fault", 32'(bus.fault), 32'h0);

        for (int i = 0; i < 3; i++) begin
            run_op(OP_NONE, 32'h0, 1'b1);
            check_eq("idle_we", 32'(bus.reg_write_en), 32'h0);
        end
        check_eq("idle_pc",    32'(bus.pc), 32'h3);
        check_eq("idle_empty", 32'(bus.stack_empty), 32'h1);

        run_op(OP_JMP, 32'h5, 1'b1);
        check_eq("jmp_pc", 32'(bus.pc), 32'h5);
        run_op(OP_CALL, 32'h40, 1'b1);
        check_eq("call_pc",    32'(bus.pc), 32'h40);
        check_eq("call_count", 32'(bus.stack_count), 32'h1);
        run_op(OP_RET, 32'h0, 1'b1);
        check_eq("ret_pc",    32'(bus.pc), 32'h6);
        check_eq("ret_count", 32'(bus.stack_count), 32'h0);

        run_op(OP_PUSH, 32'hDEADBEEF, 1'b1);
        check_eq("push_pc",    32'(bus.pc), 32'h7);
        check_eq("push_count", 32'(bus.stack_count), 32'h1);
        check_eq("push_we",    32'(bus.reg_write_en), 32'h0);
        run_op(OP_POP, 32'h7, 1'b1);
        check_eq("pop_we",    32'(bus.reg_write_en), 32'h1);
        check_eq("pop_addr",  32'(bus.reg_write_addr), 32'h7);
        check_eq("pop_data",  bus.reg_write_data, 32'hDEADBEEF);
        check_eq("pop_count", 32'(bus.stack_count), 32'h0);
        check_eq("pop_empty", 32'(bus.stack_empty), 32'h1);
        check_eq("pop_pc",    32'(bus.pc), 32'h8);
        run_op(OP_NONE, 32'h0, 1'b1);
        check_eq("pop_we_clr",   32'(bus.reg_write_en), 32'h0);
        check_eq("pop_addr_clr", 32'(bus.reg_write_addr), 32'h0);
        check_eq("pop_data_clr", bus.reg_write_data, 32'h0);
        check_eq("after_pop_pc", 32'(bus.pc), 32'h9);

        run_op(OP_SWITCH, 32'h0001_0020, 1'b1);
        check_eq("sw_pc",   32'(bus.pc), 32'h20);
        check_eq("sw_we",   32'(bus.reg_write_en), 32'h1);
        check_eq("sw_addr", 32'(bus.reg_write_addr), 32'h24);
        check_eq("sw_data", bus.reg_write_data, 32'h1);

        run_op(OP_PUSH, 32'h11, 1'b1);
        run_op(OP_PUSH, 32'h22, 1'b1);
        run_op(OP_GSA, 32'h3, 1'b1);
        check_eq("gsa_we",   32'(bus.reg_write_en), 32'h1);
        check_eq("gsa_addr", 32'(bus.reg_write_addr), 32'h3);
        check_eq("gsa_data", bus.reg_write_data, 32'h2);
        check_eq("gsa_pc",   32'(bus.pc), 32'h23);

        run_op(OP_PUSH, 32'h99, 1'b0);
        check_eq("noinit_pc",    32'(bus.pc), 32'h23);
        check_eq("noinit_count", 32'(bus.stack_count), 32'h2);
        check_eq("noinit_we",    32'(bus.reg_write_en), 32'h0);

        run_op(OP_JMP | OP_CALL, 32'h10, 1'b1);
        check_eq("prio_pc",    32'(bus.pc), 32'h10);
        check_eq("prio_count", 32'(bus.stack_count), 32'h2);

        run_op(OP_PUSH, 32'h33, 1'b1);
        run_op(OP_PUSH, 32'h44, 1'b1);
        check_eq("full_count", 32'(bus.stack_count), 32'h4);
        check_eq("full_flag",  32'(bus.stack_full), 32'h1);
        check_eq("full_pc",    32'(bus.pc), 32'h12);
        run_op(OP_PUSH, 32'h55, 1'b1);
`ifdef PC_STACK_GUARD_EN
        check_eq("ovf_fault", 32'(bus.fault), 32'h1);
        check_eq("ovf_count", 32'(bus.stack_count), 32'h4);
        check_eq("ovf_pc",    32'(bus.pc), 32'h12);
        run_op(OP_NONE, 32'h0, 1'b1);
        run_op(OP_JMP, 32'h99, 1'b1);
        check_eq("frozen_pc",    32'(bus.pc), 32'h12);
        check_eq("frozen_fault", 32'(bus.fault), 32'h1);
`else
        check_eq("wrap_count", 32'(bus.stack_count), 32'h1);
        check_eq("wrap_full",  32'(bus.stack_full), 32'h0);
        check_eq("wrap_fault", 32'(bus.fault), 32'h0);
        check_eq("wrap_pc",    32'(bus.pc), 32'h13);
        run_op(OP_POP, 32'h5, 1'b1);
        check_eq("wrap_pop_data",  bus.reg_write_data, 32'h55);
        check_eq("wrap_pop_count", 32'(bus.stack_count), 32'h0);
        run_op(OP_POP, 32'h6, 1'b1);
        check_eq("udf_data",  bus.reg_write_data, 32'h44);
        check_eq("udf_count", 32'(bus.stack_count), 32'h3);
        check_eq("udf_pc",    32'(bus.pc), 32'h15);
`endif

        apply_reset();
        check_eq("rst2_pc",    32'(bus.pc), 32'h0);
        check_eq("rst2_count", 32'(bus.stack_count), 32'h0);
        check_eq("rst2_fault", 32'(bus.fault), 32'h0);

        run_op(OP_RET, 32'h0, 1'b1);
`ifdef PC_STACK_GUARD_EN
        check_eq("udf_g_fault", 32'(bus.fault), 32'h1);
        check_eq("udf_g_count", 32'(bus.stack_count), 32'h0);
        check_eq("udf_g_pc",    32'(bus.pc), 32'h0);
`else
        check_eq("ret_wrap_count", 32'(bus.stack_count), 32'h3);
        check_eq("ret_wrap_fault", 32'(bus.fault), 32'h0);
`endif

        apply_reset();
        run_op(OP_JMP, 32'hFFFF, 1'b1);
        run_op(OP_NONE, 32'h0, 1'b1);
        check_eq("pc_wrap", 32'(bus.pc), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
